seq_cla_addsub: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor built from a single 4-bit carry-lookahead slice. The slice is reused once per cycle, LSB slice first, with the slice carry-out registered into the next cycle. It pairs with the combinational carry-lookahead unit. This block supplies the operand slices and consumes the carries over time, with a valid/ready handshake on both sides, for the datapath/ALU level.

---
 rtl/seq_cla_addsub_pkg.sv | 12 +
 rtl/seq_cla_addsub_cla4_slice.sv | 19 +
 rtl/seq_cla_addsub.sv | 103 ++++++++++
 tb/tb_seq_cla_addsub.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seq_cla_addsub_pkg.sv
// seq_cla_addsub_pkg: slice width, FSM encoding and slice-count helper shared by seq_cla_addsub
package seq_cla_addsub_pkg;
    localparam int SLICE = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    function automatic int slice_count(input int width);
        return width / SLICE;
    endfunction
endpackage

// File: rtl/seq_cla_addsub_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice exposing the full carry vector c1..c4
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic [3:0] carry
);
    import seq_cla_addsub_pkg::*;
    logic [3:0] g, p;
    assign g = a & b;
    assign p = a ^ b;
    assign carry[0] = g[0] | (p[0] & cin);
    assign carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign carry[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign carry[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum = p ^ {carry[2:0], cin};
endmodule

// File: rtl/seq_cla_addsub.sv
// seq_cla_addsub: multi-cycle add/sub reusing one 4-bit lookahead slice, LSB slice first
// Optional zero/neg result flags when SEQ_CLA_FLAGS_EN is defined.
module seq_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef SEQ_CLA_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);
    import seq_cla_addsub_pkg::*;
    localparam int NS = slice_count(WIDTH);
    localparam int IW = NS > 1 ? $clog2(NS) : 1;
    generate
        if (SLICE != 4 || WIDTH < SLICE || WIDTH % SLICE != 0) begin : g_bad_cfg
            $error("seq_cla_addsub: WIDTH must be a positive multiple of SLICE=4");
        end
    endgenerate
    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, res_nxt;
    logic [IW-1:0]    idx;
    logic             carry, last;
    logic [3:0]       s_sum, s_c;
    cla4_slice u_slice (
        .a     (a_r[idx*SLICE +: SLICE]),
        .b     (b_r[idx*SLICE +: SLICE]),
        .cin   (carry),
        .sum   (s_sum),
        .carry (s_c)
    );
    assign last = idx == IW'(NS - 1);
    always_comb begin
        res_nxt = result;
        res_nxt[idx*SLICE +: SLICE] = s_sum;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= sub ? ~b : b;
                    carry    <= sub;
                    idx      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    result <= res_nxt;
                    carry  <= s_c[3];
                    idx    <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout      <= s_c[3];
                        ovf       <= s_c[3] ^ s_c[2];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SEQ_CLA_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (state == RUN && last) begin
            zero <= res_nxt == '0;
            neg  <= res_nxt[WIDTH-1];
        end
    end
`endif
endmodule

// File: tb/tb_seq_cla_addsub.sv
// tb_seq_cla_addsub: directed and random operations checked against an arithmetic reference model
module tb_seq_cla_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
`ifdef SEQ_CLA_FLAGS_EN
    logic        zero, neg;
`endif
    int checks = 0;
    int failures = 0;

    seq_cla_addsub #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
`ifdef SEQ_CLA_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; cout on subtract means "no borrow".
    task automatic ref_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          output logic [15:0] er, output logic ec, output logic eo);
        int ux, uy, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        er = s ? x - y : x + y;
        ec = s ? (ux >= uy) : (ux + uy > 65535);
        sr = s ? sx - sy : sx + sy;
        eo = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input int hold);
        logic [15:0] er;
        logic        ec, eo;
        int          n;
        ref_op(x, y, s, er, ec, eo);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 5);
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
`ifdef SEQ_CLA_FLAGS_EN
        chk("zero", zero, er == 16'h0);
        chk("neg", neg, er[15]);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, er);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 10);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'h0003, 16'h0003, 1'b1, 0);
        run_op(16'h0001, 16'h0002, 1'b1, 2);
        run_op(16'h1234, 16'h0000, 1'b1, 0);
        for (int k = 0; k < 24; k++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
